cq_handler: RTL and testbench

CQ_HANDLER -- requirements
Module: cq_handler

---
 rtl/cq_handler.sv | 242 ++++++++++++++++++++++++
 tb/tb_cq_handler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cq_handler.sv
// cq_handler: AXI4 write slave that receives completion-queue entries into a
// ring window, turns valid-phase entries into a completion stream, and rings
// the CQ head doorbell through an AXI-Lite write master.
// Build macro: DOORBELL_COALESCE_EN. When defined, a single doorbell carries
// the latest head and skips the intermediate ones. When undefined, there is
// one doorbell per accepted entry.
module cq_handler #(
  parameter int NS_ID_WIDTH   = 4,
  parameter int NS_ADDR_WIDTH = 32,
  parameter int NS_DATA_WIDTH = 128,
  parameter int NL_ADDR_WIDTH = 32,
  parameter int NL_DATA_WIDTH = 32,
  parameter logic [NS_ADDR_WIDTH-1:0] CQ_BASE    = 'h20400,
  parameter int CQ_DEPTH = 16,
  parameter logic [NL_ADDR_WIDTH-1:0] CQ_DB_ADDR = 'h100C,
  localparam int HW = $clog2(CQ_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NS_ID_WIDTH-1:0]     ns_awid,
  input  logic [NS_ADDR_WIDTH-1:0]   ns_awaddr,
  input  logic [7:0]                 ns_awlen,
  input  logic [2:0]                 ns_awsize,
  input  logic [1:0]                 ns_awburst,
  input  logic                       ns_awvalid,
  output logic                       ns_awready,
  input  logic [NS_DATA_WIDTH-1:0]   ns_wdata,
  input  logic [NS_DATA_WIDTH/8-1:0] ns_wstrb,
  input  logic                       ns_wlast,
  input  logic                       ns_wvalid,
  output logic                       ns_wready,
  output logic [NS_ID_WIDTH-1:0]     ns_bid,
  output logic [1:0]                 ns_bresp,
  output logic                       ns_bvalid,
  input  logic                       ns_bready,
  output logic [NL_ADDR_WIDTH-1:0]   nl_awaddr,
  output logic [NL_DATA_WIDTH-1:0]   nl_wdata,
  output logic [NL_DATA_WIDTH/8-1:0] nl_wstrb,
  output logic                       nl_awvalid,
  output logic                       nl_wvalid,
  output logic                       nl_bready,
  input  logic                       nl_awready,
  input  logic                       nl_wready,
  input  logic [1:0]                 nl_bresp,
  input  logic                       nl_bvalid,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output logic [15:0]                cpl_cid,
  output logic [14:0]                cpl_status,
  output logic [HW-1:0]              cqdb_sqhead,
  output logic                       phase_err
);

  typedef enum logic {IDLE, DATA} aw_state_e;
  typedef enum logic [1:0] {DB_IDLE, DB_REQ, DB_RESP} db_state_e;

  // Exclusive upper bound of the ring window, one bit wider to avoid overflow.
  localparam logic [NS_ADDR_WIDTH:0] CQ_END =
    {1'b0, CQ_BASE} + (NS_ADDR_WIDTH+1)'(CQ_DEPTH * 16);

  aw_state_e                aw_state_q, aw_state_d;
  db_state_e                db_state_q, db_state_d;
  logic [NS_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [NS_ID_WIDTH-1:0]   awid_q, awid_d;
  logic [7:0]               awlen_q, awlen_d, beat_idx_q, beat_idx_d;
  logic                     burst_err_q, burst_err_d, bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     cpl_valid_q, cpl_valid_d, exp_phase_q, exp_phase_d;
  logic [15:0]              cpl_cid_q, cpl_cid_d;
  logic [14:0]              cpl_status_q, cpl_status_d;
  logic [HW-1:0]            cq_head_q, cq_head_d, sqhead_q, sqhead_d;
  logic                     phase_err_q, phase_err_d;
  logic [HW-1:0]            db_head_q, db_head_d, db_value_q, db_value_d;
  logic                     db_aw_done_q, db_aw_done_d, db_w_done_q, db_w_done_d;
`ifndef DOORBELL_COALESCE_EN
  logic [HW:0]              pending_q, pending_d;
`endif

  logic [NS_ADDR_WIDTH-1:0] beat_addr;
  logic in_range, aw_hs, w_hs, entry_ok, entry_stale, db_done, db_full;

  // Handshakes, beat address decode and ready generation.
  always_comb begin
    beat_addr   = awaddr_q + NS_ADDR_WIDTH'({beat_idx_q, 4'b0000});
    in_range    = ({1'b0, beat_addr} >= {1'b0, CQ_BASE}) && ({1'b0, beat_addr} < CQ_END);
`ifdef DOORBELL_COALESCE_EN
    db_full     = 1'b0;
`else
    db_full     = (pending_q == (HW+1)'(CQ_DEPTH));
`endif
    ns_awready  = (aw_state_q == IDLE) && !bvalid_q;
    // A held completion blocks new beats so nothing is ever dropped.
    ns_wready   = (aw_state_q == DATA) && !(cpl_valid_q && !cpl_ready) && !db_full;
    aw_hs       = ns_awvalid && ns_awready;
    w_hs        = ns_wvalid && ns_wready;
    entry_ok    = w_hs && in_range && (ns_wdata[112] == exp_phase_q);
    entry_stale = w_hs && in_range && (ns_wdata[112] != exp_phase_q);
    db_done     = (db_state_q == DB_RESP) && nl_bvalid;
  end

  // Next state for the AW/W/B path, the completion register and the doorbell.
  always_comb begin
    aw_state_d   = aw_state_q;
    awaddr_d     = awaddr_q;
    awid_d       = awid_q;
    awlen_d      = awlen_q;
    beat_idx_d   = beat_idx_q;
    burst_err_d  = burst_err_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    cpl_valid_d  = cpl_valid_q;
    cpl_cid_d    = cpl_cid_q;
    cpl_status_d = cpl_status_q;
    cq_head_d    = cq_head_q;
    exp_phase_d  = exp_phase_q;
    sqhead_d     = sqhead_q;
    phase_err_d  = entry_stale;
    db_state_d   = db_state_q;
    db_head_d    = db_head_q;
    db_value_d   = db_value_q;
    db_aw_done_d = db_aw_done_q;
    db_w_done_d  = db_w_done_q;

    if (bvalid_q && ns_bready) bvalid_d = 1'b0;
    case (aw_state_q)
      IDLE: if (aw_hs) begin
        awaddr_d    = ns_awaddr;
        awid_d      = ns_awid;
        awlen_d     = ns_awlen;
        beat_idx_d  = '0;
        burst_err_d = 1'b0;
        aw_state_d  = DATA;
      end
      default: if (w_hs) begin
        beat_idx_d = beat_idx_q + 8'd1;
        if (!in_range) burst_err_d = 1'b1;
        if (ns_wlast) begin
          aw_state_d = IDLE;
          bvalid_d   = 1'b1;
          bresp_d    = (burst_err_q || !in_range) ? 2'b10 : 2'b00;
        end
      end
    endcase

    if (cpl_valid_q && cpl_ready) cpl_valid_d = 1'b0;
    if (entry_ok) begin
      cpl_valid_d  = 1'b1;
      cpl_cid_d    = ns_wdata[96 +: 16];
      cpl_status_d = ns_wdata[113 +: 15];
      cq_head_d    = cq_head_q + 1'b1;
      if (cq_head_q == HW'(CQ_DEPTH - 1)) exp_phase_d = !exp_phase_q;
      sqhead_d     = ns_wdata[64 +: HW];
    end

    case (db_state_q)
      DB_IDLE: begin
`ifdef DOORBELL_COALESCE_EN
        if (db_head_q != cq_head_q) begin
          db_value_d = cq_head_q;
          db_head_d  = cq_head_q;
          db_state_d = DB_REQ;
        end
`else
        if (pending_q != '0) begin
          db_value_d = db_head_q + 1'b1;
          db_head_d  = db_head_q + 1'b1;
          db_state_d = DB_REQ;
        end
`endif
      end
      DB_REQ: begin
        db_aw_done_d = db_aw_done_q || nl_awready;
        db_w_done_d  = db_w_done_q || nl_wready;
        if ((db_aw_done_q || nl_awready) && (db_w_done_q || nl_wready)) begin
          db_aw_done_d = 1'b0;
          db_w_done_d  = 1'b0;
          db_state_d   = DB_RESP;
        end
      end
      default: if (nl_bvalid) db_state_d = DB_IDLE;
    endcase
  end

`ifndef DOORBELL_COALESCE_EN
  // Entries awaiting a doorbell; a same-cycle accept and completion cancel out.
  always_comb begin
    pending_d = pending_q;
    if (entry_ok && !db_done)      pending_d = pending_q + 1'b1;
    else if (!entry_ok && db_done) pending_d = pending_q - 1'b1;
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_state_q <= IDLE;       db_state_q <= DB_IDLE;
      awaddr_q <= '0;           awid_q <= '0;        awlen_q <= '0;
      beat_idx_q <= '0;         burst_err_q <= 1'b0;
      bvalid_q <= 1'b0;         bresp_q <= 2'b00;
      cpl_valid_q <= 1'b0;      cpl_cid_q <= '0;     cpl_status_q <= '0;
      cq_head_q <= '0;          exp_phase_q <= 1'b1; sqhead_q <= '0;
      phase_err_q <= 1'b0;      db_head_q <= '0;     db_value_q <= '0;
      db_aw_done_q <= 1'b0;     db_w_done_q <= 1'b0;
`ifndef DOORBELL_COALESCE_EN
      pending_q <= '0;
`endif
    end else begin
      aw_state_q <= aw_state_d; db_state_q <= db_state_d;
      awaddr_q <= awaddr_d;     awid_q <= awid_d;    awlen_q <= awlen_d;
      beat_idx_q <= beat_idx_d; burst_err_q <= burst_err_d;
      bvalid_q <= bvalid_d;     bresp_q <= bresp_d;
      cpl_valid_q <= cpl_valid_d; cpl_cid_q <= cpl_cid_d; cpl_status_q <= cpl_status_d;
      cq_head_q <= cq_head_d;   exp_phase_q <= exp_phase_d; sqhead_q <= sqhead_d;
      phase_err_q <= phase_err_d; db_head_q <= db_head_d; db_value_q <= db_value_d;
      db_aw_done_q <= db_aw_done_d; db_w_done_q <= db_w_done_d;
`ifndef DOORBELL_COALESCE_EN
      pending_q <= pending_d;
`endif
    end
  end

  assign ns_bid      = awid_q;
  assign ns_bresp    = bresp_q;
  assign ns_bvalid   = bvalid_q;
  assign cpl_valid   = cpl_valid_q;
  assign cpl_cid     = cpl_cid_q;
  assign cpl_status  = cpl_status_q;
  assign cqdb_sqhead = sqhead_q;
  assign phase_err   = phase_err_q;
  assign nl_awvalid  = (db_state_q == DB_REQ) && !db_aw_done_q;
  assign nl_wvalid   = (db_state_q == DB_REQ) && !db_w_done_q;
  assign nl_bready   = (db_state_q == DB_RESP);
  assign nl_awaddr   = (db_state_q == DB_REQ) ? CQ_DB_ADDR : '0;
  assign nl_wdata    = (db_state_q == DB_REQ) ? NL_DATA_WIDTH'(db_value_q) : '0;
  assign nl_wstrb    = (db_state_q == DB_REQ) ? {(NL_DATA_WIDTH/8){1'b1}} : '0;

  // Inputs and fields the datapath has no use for (INCR/16-byte beats assumed,
  // burst end taken from wlast, write response of the doorbell ignored).
  logic unused_inputs;
  assign unused_inputs = ^{ns_awsize, ns_awburst, ns_wstrb, ns_wdata, nl_bresp, awlen_q};

endmodule

// File: tb/tb_cq_handler.sv
// Randomized scoreboard bench for cq_handler. Expected completions, B responses
// and doorbell values are queued when stimulus is accepted; monitors compare.
module tb_cq_handler;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h20400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ns_awid; logic [31:0] ns_awaddr; logic [7:0] ns_awlen;
  logic [2:0] ns_awsize; logic [1:0] ns_awburst; logic ns_awvalid, ns_awready;
  logic [127:0] ns_wdata; logic [15:0] ns_wstrb; logic ns_wlast, ns_wvalid, ns_wready;
  logic [3:0] ns_bid; logic [1:0] ns_bresp; logic ns_bvalid, ns_bready;
  logic [31:0] nl_awaddr, nl_wdata; logic [3:0] nl_wstrb;
  logic nl_awvalid, nl_wvalid, nl_bready, nl_awready, nl_wready, nl_bvalid;
  logic [1:0] nl_bresp;
  logic cpl_valid, cpl_ready; logic [15:0] cpl_cid; logic [14:0] cpl_status;
  logic [3:0] cqdb_sqhead; logic phase_err;

  always #5 clk = ~clk;

  cq_handler dut (
    .clk(clk), .rst(rst),
    .ns_awid(ns_awid), .ns_awaddr(ns_awaddr), .ns_awlen(ns_awlen), .ns_awsize(ns_awsize),
    .ns_awburst(ns_awburst), .ns_awvalid(ns_awvalid), .ns_awready(ns_awready),
    .ns_wdata(ns_wdata), .ns_wstrb(ns_wstrb), .ns_wlast(ns_wlast), .ns_wvalid(ns_wvalid),
    .ns_wready(ns_wready), .ns_bid(ns_bid), .ns_bresp(ns_bresp), .ns_bvalid(ns_bvalid),
    .ns_bready(ns_bready), .nl_awaddr(nl_awaddr), .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb),
    .nl_awvalid(nl_awvalid), .nl_wvalid(nl_wvalid), .nl_bready(nl_bready),
    .nl_awready(nl_awready), .nl_wready(nl_wready), .nl_bresp(nl_bresp), .nl_bvalid(nl_bvalid),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid), .cpl_status(cpl_status),
    .cqdb_sqhead(cqdb_sqhead), .phase_err(phase_err)
  );

  typedef struct packed { logic [15:0] cid; logic [14:0] st; } cpl_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  cpl_t cpl_q[$];
  b_t   b_q[$];
  int   db_q[$];

  int checks = 0, failures = 0;
  // Reference model: ring head, expected phase, last reported SQ head.
  int m_head, m_entries, perr_exp, perr_seen, db_cnt, last_db;
  bit m_exp, b_err;
  logic [3:0] m_sqhead;
  int cpl_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit b_rand = 1'b0, aw_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // AXI-Lite slave and stream sink behaviour, updated just after each edge.
  initial begin
    nl_awready = 1'b0; nl_wready = 1'b0; nl_bvalid = 1'b0; nl_bresp = 2'b00;
    cpl_ready = 1'b1; ns_bready = 1'b1;
    forever begin
      @(posedge clk); #1;
      nl_awready = aw_stall ? 1'b0 : 1'($urandom_range(0, 1));
      nl_wready  = 1'($urandom_range(0, 1));
      nl_bvalid  = 1'($urandom_range(0, 1));
      nl_bresp   = 2'($urandom_range(0, 3));
      cpl_ready  = (cpl_mode == 0) ? 1'b0 : (cpl_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ns_bready  = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes an output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpl_valid && cpl_ready) begin
        cpl_t e;
        if (cpl_q.size() == 0) fail("cpl_unexpected", int'(cpl_cid), -1);
        else begin
          e = cpl_q.pop_front();
          check("cpl_cid", 32'(cpl_cid), 32'(e.cid));
          check("cpl_status", 32'(cpl_status), 32'(e.st));
          $display("cpl  cid=%0h status=%0h", cpl_cid, cpl_status);
        end
      end
      if (ns_bvalid && ns_bready) begin
        b_t e;
        if (b_q.size() == 0) fail("b_unexpected", int'(ns_bresp), -1);
        else begin
          e = b_q.pop_front();
          check("bid", 32'(ns_bid), 32'(e.id));
          check("bresp", 32'(ns_bresp), 32'(e.resp));
          $display("b    id=%0h resp=%0h", ns_bid, ns_bresp);
        end
      end
      if (nl_awvalid && nl_awready) check("db_awaddr", nl_awaddr, 32'h100C);
      if (nl_wvalid && nl_wready) begin
        check("db_wstrb", 32'(nl_wstrb), 32'hF);
        db_cnt++;
        last_db = int'(nl_wdata);
        $display("db   data=%0h", nl_wdata);
`ifndef DOORBELL_COALESCE_EN
        if (db_q.size() == 0) fail("db_unexpected", int'(nl_wdata), -1);
        else check("db_wdata", nl_wdata, 32'(db_q.pop_front()));
`endif
      end
      if (phase_err) perr_seen++;
    end
  end

  // An accepted beat, judged purely by the ring window and phase rules.
  task automatic model_accept(input logic [31:0] addr, input logic [127:0] d);
    if (addr >= BASE && addr < BASE + 32'(DEPTH * 16)) begin
      if (d[112] == m_exp) begin
        cpl_q.push_back({d[96 +: 16], d[113 +: 15]});
        m_head = (m_head + 1) % DEPTH;
        if (m_head == 0) m_exp = ~m_exp;
        m_sqhead = d[67:64];
        m_entries++;
`ifndef DOORBELL_COALESCE_EN
        db_q.push_back(m_head);
`endif
      end else perr_exp++;
    end else b_err = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; ns_awvalid = 1'b0; ns_wvalid = 1'b0; ns_wlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cpl_q.delete(); b_q.delete(); db_q.delete();
    m_head = 0; m_exp = 1'b1; m_sqhead = '0; m_entries = 0;
    perr_exp = 0; perr_seen = 0; db_cnt = 0; last_db = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    pulse_reset();
  endtask

  // phase_mode: 0 expected phase, 1 force 1, 2 force 0, 3 mostly expected.
  task automatic send_burst(input logic [31:0] addr, input int nbeats, input int abort_at,
                            input int phase_mode, input bit directed,
                            input logic [15:0] cid0, input logic [15:0] sqh0);
    logic [127:0] d;
    logic [3:0] id;
    bit ok;
    id = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    ns_awid = id; ns_awaddr = addr; ns_awlen = 8'(nbeats - 1);
    ns_awsize = 3'd4; ns_awburst = 2'b01; ns_awvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin @(negedge clk); ok = ns_awready; end
    if (!ok) begin fail("aw_timeout", 0, 1); ns_awvalid = 1'b0; return; end
    @(posedge clk); #1;
    ns_awvalid = 1'b0;
    b_err = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (directed) begin
        d[96 +: 16] = cid0 + 16'(i);
        d[64 +: 16] = sqh0 + 16'(i);
      end
      case (phase_mode)
        0:       d[112] = m_exp;
        1:       d[112] = 1'b1;
        2:       d[112] = 1'b0;
        default: d[112] = ($urandom_range(0, 4) != 0) ? m_exp : ~m_exp;
      endcase
      ns_wdata = d; ns_wstrb = '1; ns_wlast = (i == nbeats - 1); ns_wvalid = 1'b1;
      if (i == abort_at) begin
        @(negedge clk);
        pulse_reset();
        return;
      end
      ok = 1'b0;
      for (int t = 0; t < 1000 && !ok; t++) begin @(negedge clk); ok = ns_wready; end
      if (!ok) begin fail("w_timeout", 0, 1); ns_wvalid = 1'b0; return; end
      @(posedge clk);
      model_accept(addr + 32'(16 * i), d);
      #1;
    end
    ns_wvalid = 1'b0; ns_wlast = 1'b0;
    b_q.push_back({id, b_err ? 2'b10 : 2'b00});
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    cpl_mode = 1; b_rand = 1'b0; aw_stall = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = (cpl_q.size() == 0) && (b_q.size() == 0) && (db_q.size() == 0);
    end
    if (!ok) fail("drain_timeout", cpl_q.size() + b_q.size() + db_q.size(), 0);
    repeat (100) @(negedge clk);
    check("cqdb_sqhead", 32'(cqdb_sqhead), 32'(m_sqhead));
    check("phase_err_count", 32'(perr_seen), 32'(perr_exp));
    check("db_idle", 32'({nl_awvalid, nl_wvalid}), 32'd0);
`ifdef DOORBELL_COALESCE_EN
    if (m_entries == 0) check("db_none", 32'(db_cnt), 32'd0);
    else check("db_final", 32'(last_db), 32'(m_head));
`else
    check("db_count", 32'(db_cnt), 32'(m_entries));
`endif
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bit seen;
    ns_awid = '0; ns_awaddr = '0; ns_awlen = '0; ns_awsize = '0; ns_awburst = '0;
    ns_awvalid = 1'b0; ns_wdata = '0; ns_wstrb = '0; ns_wlast = 1'b0; ns_wvalid = 1'b0;

    // Reset state, first cycle after reset.
    reset_dut();
    check("rst_awready", 32'(ns_awready), 32'd1);
    check("rst_bvalid", 32'(ns_bvalid), 32'd0);
    check("rst_bresp", 32'(ns_bresp), 32'd0);
    check("rst_cpl_valid", 32'(cpl_valid), 32'd0);
    check("rst_nl_valid", 32'({nl_awvalid, nl_wvalid}), 32'd0);
    check("rst_sqhead", 32'(cqdb_sqhead), 32'd0);
    check("rst_phase_err", 32'(phase_err), 32'd0);

    // Single entry: cid 5, sqhead 1, doorbell data 1.
    send_burst(BASE, 1, -1, 1, 1'b1, 16'd5, 16'd1);
    drain();
    check("single_sqhead", 32'(cqdb_sqhead), 32'd1);

    // Full ring with phase 1, then a stale entry, then the wrapped phase 0.
    reset_dut();
    for (int k = 0; k < DEPTH; k++) send_burst(BASE + 32'(16 * k), 1, -1, 1, 1'b1, 16'(100 + k), 16'(k));
    send_burst(BASE, 1, -1, 1, 1'b1, 16'd200, 16'd2);
    send_burst(BASE, 1, -1, 2, 1'b1, 16'd201, 16'd3);
    drain();
    check("wrap_phase_err", 32'(perr_seen), 32'd1);

    // Out-of-window write: SLVERR, no completion, no doorbell.
    reset_dut();
    send_burst(32'h0, 1, -1, 1, 1'b1, 16'd7, 16'd7);
    drain();
    check("oor_db_count", 32'(db_cnt), 32'd0);

    // Completion backpressure holds off W after the first entry.
    reset_dut();
    cpl_mode = 0;
    fork
      send_burst(BASE, 3, -1, 0, 1'b1, 16'd10, 16'd3);
      begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin @(negedge clk); seen = cpl_valid; end
        if (!seen) fail("stall_cpl_timeout", 0, 1);
        check("stall_wready", 32'(ns_wready), 32'd0);
        repeat (10) @(negedge clk);
        check("stall_wready_held", 32'(ns_wready), 32'd0);
        @(posedge clk); #1 cpl_mode = 1;
      end
    join
    drain();

    // Doorbell address channel stalled while four entries arrive.
    reset_dut();
    aw_stall = 1'b1;
    for (int k = 0; k < 4; k++) send_burst(BASE + 32'(16 * k), 1, -1, 0, 1'b1, 16'(30 + k), 16'(k));
    repeat (20) @(posedge clk);
    #1 aw_stall = 1'b0;
    drain();

    // Reset during the third beat of a four-beat burst, then a clean write.
    reset_dut();
    send_burst(BASE, 4, 2, 0, 1'b1, 16'd20, 16'd7);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_b", 32'(ns_bvalid), 32'd0);
      check("abort_no_cpl", 32'(cpl_valid), 32'd0);
    end
    check("abort_sqhead", 32'(cqdb_sqhead), 32'd0);
    send_burst(BASE, 1, -1, 1, 1'b1, 16'd5, 16'd1);
    drain();
    check("abort_then_single_sqhead", 32'(cqdb_sqhead), 32'd1);

    // Randomized bursts with random backpressure on every channel.
    reset_dut();
    cpl_mode = 2; b_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = BASE + 32'(16 * $urandom_range(0, 15));
      else if (r < 9) a = BASE - 32'(16 * $urandom_range(1, 2));
      else            a = 32'h1000 * 32'($urandom_range(0, 3));
      send_burst(a, int'($urandom_range(1, 4)), -1, 3, 1'b0, 16'd0, 16'd0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
